// File: rtl/md_sequencer_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer.
package md_sequencer_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULT  = 2'b00,
        MD_OP_MULTU = 2'b01,
        MD_OP_DIV   = 2'b10,
        MD_OP_DIVU  = 2'b11
    } mdOp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdState_t;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } mdRes_t;

endpackage

// File: rtl/md_sequencer_if.sv
// EX-side issue bus, ID-side hazard probe and HI/LO read-out of the md sequencer.
interface md_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        id_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, opa, opb, mthi, mtlo, wdata, id_md,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, op, opa, opb, mthi, mtlo, wdata, id_md,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/md_sequencer_arith.sv
// Combinational signed/unsigned 32x32 multiply and divide; zero latency.
// Flags a zero divisor so the caller can leave HI/LO untouched.
module md_arith
    import md_sequencer_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output mdRes_t      res
);
    logic [63:0] prodS;
    logic [63:0] prodU;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        isSigned;
    logic        negQ;
    logic        negR;

    always_comb begin
        prodS    = {{32{opa[31]}}, opa} * {{32{opb[31]}}, opb};
        prodU    = {32'b0, opa} * {32'b0, opb};
        isSigned = (op == MD_OP_DIV);
        negR     = isSigned & opa[31];
        negQ     = isSigned & (opa[31] ^ opb[31]);
        magA     = negR ? -opa : opa;
        magB     = (isSigned & opb[31]) ? -opb : opb;
        // Divisor forced non-zero so the divider never sees 0; result is discarded via div0.
        divisor  = (magB == 32'd0) ? 32'd1 : magB;
        quo      = magA / divisor;
        rem      = magA % divisor;

        res = '0;
        case (mdOp_t'(op))
            MD_OP_MULT: begin
                res.hi = prodS[63:32];
                res.lo = prodS[31:0];
            end
            MD_OP_MULTU: begin
                res.hi = prodU[63:32];
                res.lo = prodU[31:0];
            end
            default: begin
                res.hi   = negR ? -rem : rem;
                res.lo   = negQ ? -quo : quo;
                res.div0 = (opb == 32'd0);
            end
        endcase
    end
endmodule

// File: rtl/md_sequencer.sv
// HI/LO owner and fixed-latency mult/div sequencer: result lands N cycles after issue.
// stall = id_md & (busy | start) holds the next md instruction in ID until HI/LO settle.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic           clk,
    input  logic           rst,
    md_sequencer_if.slave  md
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdState_t         state;
    mdState_t         nextState;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pendHi;
    logic [31:0]      pendLo;
    logic             pendDiv0;
    logic [31:0]      hiReg;
    logic [31:0]      loReg;
    logic             lastCycle;
    mdRes_t           res;

    md_arith uArith (
        .op  (md.op),
        .opa (md.opa),
        .opb (md.opb),
        .res (res)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        lastCycle = 1'b0;
        case (state)
            IDLE: if (md.start) nextState = BUSY;
            BUSY: begin
                lastCycle = (cnt == CNT_W'(1));
                if (lastCycle) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Result is captured at issue so forwarded operands need not be held during BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            pendHi   <= '0;
            pendLo   <= '0;
            pendDiv0 <= 1'b0;
            hiReg    <= '0;
            loReg    <= '0;
        end else if (state == IDLE) begin
            if (md.start) begin
                pendHi   <= res.hi;
                pendLo   <= res.lo;
                pendDiv0 <= res.div0;
                cnt      <= md.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else begin
                if (md.mthi) hiReg <= md.wdata;
                if (md.mtlo) loReg <= md.wdata;
            end
        end else begin
            cnt <= cnt - CNT_W'(1);
            if (lastCycle && !pendDiv0) begin
                hiReg <= pendHi;
                loReg <= pendLo;
            end
        end
    end

    assign md.busy  = (state == BUSY);
    assign md.stall = md.id_md & (md.busy | md.start);
    assign md.hi    = hiReg;
    assign md.lo    = loReg;

    // A correctly wired hazard unit never lets another md op reach EX while busy.
    assert property (@(posedge clk) disable iff (rst) md.busy |-> !(md.start || md.mthi || md.mtlo));

endmodule

// File: tb/tb_md_sequencer.sv
// Directed plus randomized bench for md_sequencer against a countdown/arithmetic reference model.
module tb_md_sequencer;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    md_sequencer_if bus ();

    md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk (clk),
        .rst (rst),
        .md  (bus)
    );

    int nVec = 0;
    int nErr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on 64-bit integers: returns {div0, hi, lo}.
    function automatic logic [64:0] refOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     p;
        longint     q;
        longint     r;
        logic [63:0] u;
        logic [64:0] out;
        out = '0;
        case (op)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                out = {1'b0, p[63:0]};
            end
            2'b01: begin
                u = {32'b0, a} * {32'b0, b};
                out = {1'b0, u};
            end
            2'b10: begin
                if (b == 32'd0) out[64] = 1'b1;
                else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    out = {1'b0, r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) out[64] = 1'b1;
                else begin
                    q = longint'({32'b0, a}) / longint'({32'b0, b});
                    r = longint'({32'b0, a}) % longint'({32'b0, b});
                    out = {1'b0, r[31:0], q[31:0]};
                end
            end
        endcase
        return out;
    endfunction

    logic [31:0] mHi, mLo, mPHi, mPLo;
    logic        mPz;
    int          mLeft = 0;
    bit          mValid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mHi = '0; mLo = '0; mPHi = '0; mPLo = '0; mPz = 1'b0;
            mLeft = 0;
            mValid = 1'b1;
        end else if (mLeft > 0) begin
            mLeft--;
            if (mLeft == 0 && !mPz) begin
                mHi = mPHi;
                mLo = mPLo;
            end
        end else if (bus.start) begin
            {mPz, mPHi, mPLo} = refOp(bus.op, bus.opa, bus.opb);
            mLeft = bus.op[1] ? DIV_N : MULT_N;
        end else begin
            if (bus.mthi) mHi = bus.wdata;
            if (bus.mtlo) mLo = bus.wdata;
        end
    end

    always @(negedge clk) begin
        if (mValid) begin
            chk("model_busy",  {31'b0, bus.busy},  {31'b0, mLeft > 0});
            chk("model_stall", {31'b0, bus.stall}, {31'b0, bus.id_md & ((mLeft > 0) | bus.start)});
            chk("model_hi", bus.hi, mHi);
            chk("model_lo", bus.lo, mLo);
        end
    end

    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] preHi, input logic [31:0] preLo,
                         input logic [31:0] expHi, input logic [31:0] expLo);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.opa = a; bus.opb = b; bus.id_md = 1'b1;
        @(negedge clk);
        chk({tag, "_stall_issue"}, {31'b0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_busy"},  {31'b0, bus.busy},  32'd1);
            chk({tag, "_stall"}, {31'b0, bus.stall}, 32'd1);
            chk({tag, "_hi_hold"}, bus.hi, preHi);
            chk({tag, "_lo_hold"}, bus.lo, preLo);
        end
        @(negedge clk);
        chk({tag, "_busy_end"},  {31'b0, bus.busy},  32'd0);
        chk({tag, "_stall_end"}, {31'b0, bus.stall}, 32'd0);
        chk({tag, "_hi"}, bus.hi, expHi);
        chk({tag, "_lo"}, bus.lo, expLo);
        @(posedge clk); #1;
        bus.id_md = 1'b0;
    endtask

    task automatic mtWrite(input logic hiEn, input logic loEn, input logic [31:0] d);
        @(posedge clk); #1;
        bus.mthi = hiEn; bus.mtlo = loEn; bus.wdata = d;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.opa = '0; bus.opb = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0; bus.id_md = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_hi",    bus.hi, 32'd0);
        chk("rst_lo",    bus.lo, 32'd0);
        chk("rst_busy",  {31'b0, bus.busy},  32'd0);
        chk("rst_stall", {31'b0, bus.stall}, 32'd0);

        runOp("mult",  2'b00, 32'hFFFF_FFFE, 32'd3, MULT_N, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        runOp("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
              32'hFFFF_FFFE, 32'h0000_0001);
        runOp("div",   2'b10, 32'hFFFF_FFF9, 32'd2, DIV_N, 32'hFFFF_FFFE, 32'h0000_0001,
              32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
              32'h0, 32'h8000_0000);

        mtWrite(1'b1, 1'b0, 32'h11);
        mtWrite(1'b0, 1'b1, 32'h22);
        @(negedge clk);
        chk("mt_hi", bus.hi, 32'h11);
        chk("mt_lo", bus.lo, 32'h22);
        chk("mt_busy", {31'b0, bus.busy}, 32'd0);
        runOp("divu0", 2'b11, 32'd7, 32'd0, DIV_N, 32'h11, 32'h22, 32'h11, 32'h22);
        mtWrite(1'b1, 1'b0, 32'hABCD);
        @(negedge clk);
        chk("mthi_abcd", bus.hi, 32'hABCD);

        // Reset arriving in the third busy cycle abandons the divide.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 2'b10; bus.opa = 32'd100; bus.opb = 32'd3; bus.id_md = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_busy",  {31'b0, bus.busy},  32'd0);
        chk("rstmid_stall", {31'b0, bus.stall}, 32'd0);
        chk("rstmid_hi", bus.hi, 32'd0);
        chk("rstmid_lo", bus.lo, 32'd0);
        @(posedge clk); #1 bus.id_md = 1'b0;

        repeat (3000) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 299) == 0);
            bus.id_md = 1'($urandom_range(0, 1));
            bus.op    = 2'($urandom_range(0, 3));
            bus.opa   = pick();
            bus.opb   = pick();
            bus.wdata = $urandom;
            if (mLeft > 0) begin
                bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
            end else begin
                bus.start = ($urandom_range(0, 3) == 0);
                bus.mthi  = ($urandom_range(0, 4) == 0);
                bus.mtlo  = ($urandom_range(0, 4) == 0);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.id_md = 1'b0;
        repeat (DIV_N + 2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
